// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: button FSM state encoding and default timing constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long-hold at the 100 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_HOLD_CYCLES     = 100000000;
    localparam int DEFAULT_CNT_WIDTH       = 27;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button input plus the conditioned level and event pulses of one pushbutton.
interface button_conditioner_if;

    logic ButtonIn;
    logic Pressed;
    logic PressPulse;
    logic ReleasePulse;
    logic HoldPulse;

    // The button source drives the raw level and consumes the conditioned events
    modport master (
        output ButtonIn,
        input  Pressed,
        input  PressPulse,
        input  ReleasePulse,
        input  HoldPulse
    );

    // The conditioner consumes the raw level and produces the conditioned events
    modport slave (
        input  ButtonIn,
        output Pressed,
        output PressPulse,
        output ReleasePulse,
        output HoldPulse
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw input through the two synchronizing stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces one pushbutton and emits press, release and long-hold pulses.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    button_conditioner_if.slave   btn
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 sync_btn;
    btn_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hold_save_q, hold_save_d;
    logic                 hold_fired_q, hold_fired_d;
    logic                 pressed_q, pressed_d;
    logic                 press_pulse_q, press_pulse_d;
    logic                 release_pulse_q, release_pulse_d;
    logic                 hold_pulse_q, hold_pulse_d;

    sync_2ff u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (btn.ButtonIn),
        .q   (sync_btn)
    );

    // Next state: debounce in the wait states, hold counting while down, pulses on acceptance
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hold_save_d     = hold_save_q;
        hold_fired_d    = hold_fired_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        hold_pulse_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_btn) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = DOWN;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if ((cnt_q == HOLD_LAST) && !hold_fired_q) begin
                    hold_pulse_d = 1'b1;
                    hold_fired_d = 1'b1;
                end
                if (!sync_btn) begin
                    state_d     = RELEASE_WAIT;
                    hold_save_d = cnt_q;
                    cnt_d       = '0;
                end else if (cnt_q < HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync_btn) begin
                    state_d = DOWN;
                    cnt_d   = hold_save_q;
                end else if (cnt_q == DEB_LAST) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                    hold_fired_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == DOWN) || (state_d == RELEASE_WAIT);
    end

    // State, counters and registered outputs, all cleared asynchronously
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            hold_save_q     <= '0;
            hold_fired_q    <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            hold_pulse_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_save_q     <= hold_save_d;
            hold_fired_q    <= hold_fired_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            hold_pulse_q    <= hold_pulse_d;
        end
    end

    assign btn.Pressed      = pressed_q;
    assign btn.PressPulse   = press_pulse_q;
    assign btn.ReleasePulse = release_pulse_q;
    assign btn.HoldPulse    = hold_pulse_q;

endmodule
